// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//   Shared constants for the UART transmit-side blocks.
//   - UART_DATA_WIDTH : default byte width, must match the transmitter.
//   - ST_*            : arbiter FSM encodings (3-bit, legacy-compatible).
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int UART_DATA_WIDTH = 8;

  localparam int ST_W = 3;

  localparam logic [ST_W-1:0] ST_ARB       = 3'd0;
  localparam logic [ST_W-1:0] ST_ISSUE     = 3'd1;
  localparam logic [ST_W-1:0] ST_WAIT_BUSY = 3'd2;
  localparam logic [ST_W-1:0] ST_WAIT_DONE = 3'd3;
  localparam logic [ST_W-1:0] ST_GAP       = 3'd4;

endpackage

// File: rtl/uart_rr_select.sv
// ---------------------------------------------------------------------------
// uart_rr_select
//   Combinational round-robin picker. Searches upward from i_last_grant+1
//   (wrapping modulo NUM_REQ) for the first request that is also enabled in
//   i_mask. The last-granted requester is therefore considered last.
//
//   i_req        : per-requester request
//   i_mask       : per-requester enable (eligibility)
//   i_last_grant : index of the previously granted requester
//   o_grant      : one-hot winner (all zero when nothing eligible)
//   o_idx        : binary index of the winner
//   o_any        : at least one eligible request present
// ---------------------------------------------------------------------------
module uart_rr_select #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [NUM_REQ-1:0] i_mask,
  input  logic [IDX_W-1:0]   i_last_grant,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any
);

  // One extra bit so last_grant + NUM_REQ never overflows before the wrap.
  localparam logic [IDX_W:0] NREQ_W = (IDX_W+1)'(NUM_REQ);

  logic [NUM_REQ-1:0] elig;
  logic [IDX_W:0]     pos;

  always_comb begin
    elig    = i_req & i_mask;
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    pos     = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      pos = {1'b0, i_last_grant} + (IDX_W+1)'(off);
      if (pos >= NREQ_W) pos = pos - NREQ_W;
      if (!o_any && elig[pos[IDX_W-1:0]]) begin
        o_any                     = 1'b1;
        o_grant[pos[IDX_W-1:0]]   = 1'b1;
        o_idx                     = pos[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//   Shares one uart_tx between NUM_REQ byte-stream requesters using
//   round-robin arbitration, optional packet locking, an optional inter-frame
//   gap and a lost-handshake timeout.
//
//   i_clk_sys / i_rst_n : clock, async active-low reset
//   i_req_valid/data/last : per-requester byte offer (data packed, lane k at
//                           [k*DATA_WIDTH +: DATA_WIDTH])
//   o_req_ready   : one-hot, one-cycle accept pulse
//   o_tx_data     : byte to transmitter (held until the next grant)
//   o_tx_valid    : one-cycle data-valid to transmitter
//   i_tx_idle     : transmitter idle flag
//   o_grant_id    : current / last granted requester
//   o_busy        : high from grant until the arbiter is back in ARB
//   o_err_timeout : one-cycle pulse when the transmitter never left idle
//
//   Flow: ARB -> ISSUE (1 cycle, valid+ready) -> WAIT_BUSY (idle must fall)
//         -> WAIT_DONE (idle must rise) -> [GAP] -> ARB.
// ---------------------------------------------------------------------------
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int NUM_REQ     = 4,
  parameter  int DATA_WIDTH  = UART_DATA_WIDTH,
  parameter  int LOCK_PACKET = 1,
  parameter  int GAP_CYCLES  = 0,
  parameter  int ACK_TIMEOUT = 8,
  localparam int IDX_W       = $clog2(NUM_REQ)
) (
  input  logic                          i_clk_sys,
  input  logic                          i_rst_n,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
  input  logic [NUM_REQ-1:0]            i_req_last,
  output logic [NUM_REQ-1:0]            o_req_ready,
  output logic [DATA_WIDTH-1:0]         o_tx_data,
  output logic                          o_tx_valid,
  input  logic                          i_tx_idle,
  output logic [IDX_W-1:0]              o_grant_id,
  output logic                          o_busy,
  output logic                          o_err_timeout
);

  // Timeout: the ISSUE cycle plus ACK_TIMEOUT-1 WAIT_BUSY cycles make up the
  // ACK_TIMEOUT cycles after o_tx_valid; the pulse lands on the next cycle.
  localparam logic [7:0] ACK_LAST = 8'(ACK_TIMEOUT - 2);
  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_GRANT_RST = IDX_W'(NUM_REQ - 1);

  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_data_a;
  assign req_data_a = i_req_data;

  logic [ST_W-1:0]       state_q, state_d;
  logic [IDX_W-1:0]      last_grant_q, last_grant_d;
  logic [IDX_W-1:0]      grant_id_q, grant_id_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  last_q, last_d;
  logic                  lock_q, lock_d;
  logic                  busy_q, busy_d;
  logic                  tx_valid_q, tx_valid_d;
  logic [NUM_REQ-1:0]    req_ready_q, req_ready_d;
  logic                  err_q, err_d;
  logic [7:0]            cnt_q, cnt_d;

  // While a packet is locked only its owner (the last grant) is eligible.
  logic [NUM_REQ-1:0] mask;
  always_comb begin
    mask = '1;
    if (lock_q) begin
      mask               = '0;
      mask[last_grant_q] = 1'b1;
    end
  end

  logic [NUM_REQ-1:0] sel_onehot;
  logic [IDX_W-1:0]   sel_idx;
  logic               sel_any;

  uart_rr_select #(.NUM_REQ(NUM_REQ)) u_rr_select (
    .i_req        (i_req_valid),
    .i_mask       (mask),
    .i_last_grant (last_grant_q),
    .o_grant      (sel_onehot),
    .o_idx        (sel_idx),
    .o_any        (sel_any)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    tx_data_d    = tx_data_q;
    last_d       = last_q;
    lock_d       = lock_q;
    busy_d       = busy_q;
    cnt_d        = cnt_q;
    tx_valid_d   = 1'b0;
    req_ready_d  = '0;
    err_d        = 1'b0;

    case (state_q)
      ST_ARB: begin
        if (i_tx_idle && sel_any) begin
          tx_data_d    = req_data_a[sel_idx];
          last_d       = i_req_last[sel_idx];
          grant_id_d   = sel_idx;
          last_grant_d = sel_idx;
          busy_d       = 1'b1;
          // valid/ready are registered so they appear during ISSUE.
          tx_valid_d   = 1'b1;
          req_ready_d  = sel_onehot;
          state_d      = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        if (LOCK_PACKET != 0) lock_d = ~last_q;
        cnt_d   = '0;
        state_d = ST_WAIT_BUSY;
      end

      ST_WAIT_BUSY: begin
        if (!i_tx_idle) begin
          state_d = ST_WAIT_DONE;
        end else if (cnt_q == ACK_LAST) begin
          // Byte is lost (already acked upstream); drop any lock so the
          // other requesters are not starved by a dead packet.
          err_d   = 1'b1;
          lock_d  = 1'b0;
          busy_d  = 1'b0;
          state_d = ST_ARB;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      ST_WAIT_DONE: begin
        if (i_tx_idle) begin
          if (GAP_CYCLES > 0) begin
            cnt_d   = '0;
            state_d = ST_GAP;
          end else begin
            busy_d  = 1'b0;
            state_d = ST_ARB;
          end
        end
      end

      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          busy_d  = 1'b0;
          state_d = ST_ARB;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      default: begin
        busy_d  = 1'b0;
        state_d = ST_ARB;
      end
    endcase
  end

  always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_ARB;
      last_grant_q <= LAST_GRANT_RST;
      grant_id_q   <= '0;
      tx_data_q    <= '0;
      last_q       <= 1'b0;
      lock_q       <= 1'b0;
      busy_q       <= 1'b0;
      tx_valid_q   <= 1'b0;
      req_ready_q  <= '0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      tx_data_q    <= tx_data_d;
      last_q       <= last_d;
      lock_q       <= lock_d;
      busy_q       <= busy_d;
      tx_valid_q   <= tx_valid_d;
      req_ready_q  <= req_ready_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
    end
  end

  assign o_req_ready   = req_ready_q;
  assign o_tx_data     = tx_data_q;
  assign o_tx_valid    = tx_valid_q;
  assign o_grant_id    = grant_id_q;
  assign o_busy        = busy_q;
  assign o_err_timeout = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
//   Randomized + directed bench. A timestamp-based reference model predicts
//   every output each cycle; a simple transmitter model drives i_tx_idle.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  localparam int NR    = 4;
  localparam int DW    = 8;
  localparam int LOCKP = 1;
  localparam int GAP   = 3;
  localparam int ACK   = 8;
  localparam int FRAME = 10;
  localparam int IW    = $clog2(NR);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n = 1'b0;
  logic [NR-1:0]      req_valid = '0;
  logic [NR*DW-1:0]   req_data = '0;
  logic [NR-1:0]      req_last = '0;
  logic [NR-1:0]      req_ready;
  logic [DW-1:0]      tx_data;
  logic               tx_valid;
  logic               tx_idle = 1'b1;
  logic [IW-1:0]      grant_id;
  logic               busy;
  logic               err;

  uart_tx_arbiter #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .LOCK_PACKET(LOCKP),
    .GAP_CYCLES(GAP), .ACK_TIMEOUT(ACK)
  ) dut (
    .i_clk_sys(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .i_req_data(req_data), .i_req_last(req_last),
    .o_req_ready(req_ready), .o_tx_data(tx_data), .o_tx_valid(tx_valid),
    .i_tx_idle(tx_idle), .o_grant_id(grant_id), .o_busy(busy),
    .o_err_timeout(err)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // requester byte queues (ring buffers)
  logic [DW-1:0] fd [NR][256];
  logic          fl [NR][256];
  int            head [NR];
  int            tail [NR];
  logic          pres [NR];
  logic          rst_want = 1'b0;
  bit            rand_pres = 0;

  // transmitter model: line busy (idle low) during [tx_lo_from, tx_lo_to]
  int tx_lo_from = 1, tx_lo_to = 0;
  int ign_pct = 0;
  bit ign_next = 0;
  bit rand_len = 0;

  // reference model (cycle timestamps)
  int m_arb_from, m_issue, m_ack, m_done, m_err, m_lock, m_last_g, m_grant;
  logic [DW-1:0] m_data;

  int g_log[$];
  int v_cyc[$];
  int e_cyc[$];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_arb_from = 0; m_issue = -1; m_ack = -1; m_done = -1; m_err = -1;
    m_lock = -1; m_last_g = NR - 1; m_grant = 0; m_data = '0;
  endtask

  task automatic clear_reqs();
    for (int k = 0; k < NR; k++) begin
      head[k] = 0; tail[k] = 0; pres[k] = 1'b0;
    end
  endtask

  task automatic push(int k, logic [DW-1:0] d, logic l);
    fd[k][tail[k] & 255] = d;
    fl[k][tail[k] & 255] = l;
    tail[k]++;
  endtask

  function automatic bit queues_empty();
    for (int k = 0; k < NR; k++) if (head[k] != tail[k]) return 0;
    return 1;
  endfunction

  task automatic drive();
    if (rst_n && !rst_want) begin
      model_reset(); clear_reqs();
      tx_lo_from = 1; tx_lo_to = 0;
    end
    rst_n = rst_want;
    for (int k = 0; k < NR; k++) begin
      if (!pres[k] && head[k] != tail[k] && (!rand_pres || $urandom_range(1, 0) == 1))
        pres[k] = 1'b1;
      req_valid[k] = pres[k];
      req_data[k*DW +: DW] = pres[k] ? fd[k][head[k] & 255] : DW'($urandom);
      req_last[k] = pres[k] ? fl[k][head[k] & 255] : 1'($urandom);
    end
    tx_idle = !(cyc >= tx_lo_from && cyc <= tx_lo_to);
  endtask

  task automatic compare();
    logic exp_v;
    exp_v = (cyc == m_issue);
    chk("tx_valid", tx_valid, exp_v);
    chk("req_ready", req_ready, exp_v ? (64'd1 << m_grant) : 64'd0);
    chk("busy", busy, !(m_arb_from >= 0 && cyc >= m_arb_from));
    chk("err_timeout", err, cyc == m_err);
    chk("tx_data", tx_data, m_data);
    chk("grant_id", grant_id, m_grant);
  endtask

  task automatic observe();
    for (int k = 0; k < NR; k++)
      if (req_ready[k]) begin head[k]++; pres[k] = 1'b0; end
    if (tx_valid) begin
      g_log.push_back(int'(grant_id));
      v_cyc.push_back(cyc);
      if (ign_next || $urandom_range(99, 0) < ign_pct) begin
        ign_next = 0;
      end else begin
        tx_lo_from = cyc + 1;
        tx_lo_to   = cyc + (rand_len ? $urandom_range(14, 2) : FRAME);
      end
    end
    if (err) e_cyc.push_back(cyc);
  endtask

  // Predict the outputs for the next cycle from this cycle's inputs.
  task automatic model_step();
    int w;
    logic [NR-1:0] elig;
    if (m_arb_from >= 0 && cyc >= m_arb_from) begin
      elig = req_valid;
      if (m_lock >= 0) begin
        elig = '0;
        elig[m_lock] = req_valid[m_lock];
      end
      if (tx_idle && elig != '0) begin
        w = -1;
        for (int s = 1; s <= NR; s++)
          if (w < 0 && elig[(m_last_g + s) % NR]) w = (m_last_g + s) % NR;
        m_last_g = w; m_grant = w; m_data = req_data[w*DW +: DW];
        m_issue = cyc + 1; m_arb_from = -1; m_ack = -1; m_done = -1;
        if (LOCKP != 0) m_lock = req_last[w] ? -1 : w;
      end
    end else if (m_issue >= 0 && m_ack < 0 && cyc > m_issue) begin
      if (!tx_idle) m_ack = cyc;
      else if (cyc == m_issue + ACK - 1) begin
        m_err = cyc + 1; m_arb_from = cyc + 1; m_lock = -1; m_issue = -1;
      end
    end else if (m_ack >= 0 && m_done < 0 && cyc > m_ack) begin
      if (tx_idle) begin m_done = cyc; m_arb_from = cyc + 1 + GAP; end
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
    cyc++;
    drive();
    @(negedge clk);
    compare();
    observe();
    if (rst_n) model_step();
  endtask

  task automatic drain(string name, int bound);
    int n;
    n = 0;
    while ((!queues_empty() || busy || cyc <= tx_lo_to) && n < bound) begin
      step(); n++;
    end
    chk(name, n < bound, 1);
    repeat (2) step();
  endtask

  task automatic log_chk(string name, int idx, int exp);
    chk(name, (g_log.size() > idx) ? g_log[idx] : -1, exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int rr_exp[5];
    int lk_exp[4];
    int pcyc;
    int k;
    int len;
    rr_exp = '{0, 1, 2, 3, 0};
    lk_exp = '{1, 1, 1, 2};
    model_reset();
    clear_reqs();

    repeat (3) step();
    chk("reset_outputs", {tx_valid, req_ready, busy, err, tx_data, grant_id}, 0);
    rst_want = 1'b1;
    step();

    // round robin from reset: requester 0 first
    g_log.delete(); v_cyc.delete();
    for (int r = 0; r < NR; r++) begin
      push(r, 8'h10 + 8'(r), 1'b1);
      push(r, 8'h20 + 8'(r), 1'b1);
    end
    drain("rr_drain", 2000);
    for (int i = 0; i < 5; i++) log_chk("rr_order", i, rr_exp[i]);
    chk("rr_spacing", (v_cyc.size() > 1) ? v_cyc[1] - v_cyc[0] : -1, FRAME + 3 + GAP);

    // single requester
    g_log.delete(); v_cyc.delete();
    push(0, 8'h5A, 1'b1);
    pcyc = cyc + 1;
    drain("single_drain", 500);
    chk("single_latency", (v_cyc.size() > 0) ? v_cyc[0] - pcyc : -1, 1);
    chk("single_data", tx_data, 8'h5A);
    chk("single_grant", grant_id, 0);

    // packet lock: req1 three-byte packet beats req2
    g_log.delete(); v_cyc.delete();
    push(1, 8'hA1, 1'b0); push(1, 8'hA2, 1'b0); push(1, 8'hA3, 1'b1);
    push(2, 8'hB1, 1'b1);
    drain("lock_drain", 2000);
    for (int i = 0; i < 4; i++) log_chk("lock_order", i, lk_exp[i]);

    // timeout on a locking byte: lock must clear so req2 gets served
    g_log.delete(); v_cyc.delete(); e_cyc.delete();
    ign_next = 1;
    push(1, 8'hC1, 1'b0);
    push(2, 8'hC2, 1'b1);
    drain("timeout_drain", 1000);
    log_chk("timeout_first", 0, 1);
    log_chk("timeout_next", 1, 2);
    chk("timeout_delay",
        (e_cyc.size() > 0 && v_cyc.size() > 0) ? e_cyc[0] - v_cyc[0] : -1, ACK);

    // randomized traffic
    rand_pres = 1; rand_len = 1; ign_pct = 10;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(99, 0) < 15) begin
        k = $urandom_range(NR - 1, 0);
        len = $urandom_range(3, 1);
        if (tail[k] - head[k] < 200)
          for (int b = 0; b < len; b++) push(k, DW'($urandom), b == len - 1);
      end
      step();
    end
    drain("random_drain", 6000);

    // reset mid-frame
    rand_pres = 0; rand_len = 0; ign_pct = 0;
    v_cyc.delete();
    push(2, 8'hE7, 1'b1);
    while (v_cyc.size() == 0 && cyc < 90000) step();
    repeat (4) step();
    chk("mid_in_frame", {busy, tx_idle}, 2'b10);
    rst_want = 1'b0;
    step();
    chk("reset_mid_outputs", {tx_valid, req_ready, busy, err, tx_data, grant_id}, 0);
    step();
    rst_want = 1'b1;
    step();
    g_log.delete();
    for (int r = 0; r < NR; r++) push(r, 8'h70 + 8'(r), 1'b1);
    drain("post_reset_drain", 2000);
    log_chk("post_reset_first", 0, 0);
    log_chk("post_reset_second", 1, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin arbiter that shares one uart_tx transmitter between NUM_REQ byte-stream requesters.
Each requester offers a byte with valid/ready. The block selects a winner, issues a one-cycle data-valid to the transmitter, and tracks the transmitter's idle flag through the frame.
Supports optional packet locking, so a multi-byte message is not interleaved with other requesters. Supports an inter-frame gap. Flags a lost handshake when the transmitter never leaves idle.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 8, byte width; must equal the transmitter's UART_DATA_WIDTH
LOCK_PACKET, 1, 1 = hold grant until a byte with last=1 is sent; 0 = re-arbitrate after every byte
GAP_CYCLES, 0, extra i_clk_sys cycles of idle line enforced after each frame (0..255)
ACK_TIMEOUT, 8, cycles to wait for i_tx_idle to fall after issuing a byte (2..255)

Ports:
i_clk_sys  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_req_valid  in  NUM_REQ  per-requester byte valid
i_req_data  in  NUM_REQ*DATA_WIDTH  packed bytes; requester k at [k*DATA_WIDTH +: DATA_WIDTH]
i_req_last  in  NUM_REQ  byte is last of packet
o_req_ready  out  NUM_REQ  one-hot, one-cycle pulse: byte accepted
o_tx_data  out  DATA_WIDTH  to transmitter i_data_tx
o_tx_valid  out  1  to transmitter i_data_valid, one-cycle pulse
i_tx_idle  in  1  from transmitter o_uart_idle
o_grant_id  out  $clog2(NUM_REQ)  index of current/last granted requester
o_busy  out  1  high from grant until end of gap
o_err_timeout  out  1  one-cycle pulse on ACK_TIMEOUT expiry

Behaviour:
- Reset is asynchronous, active-low, on i_rst_n; clock is i_clk_sys.
- Reset values: all outputs 0. Internal state: ARB, last grant = NUM_REQ-1 (so requester 0 has first priority), lock cleared, counters 0.
- Reset mid-frame abandons the byte; no ready pulse is produced.
- Requester rule: hold valid/data/last stable until ready is seen. Valid may drop freely before grant.
- FSM states: ARB, ISSUE, WAIT_BUSY, WAIT_DONE, GAP.
- ARB:
  - Arbitrate when i_tx_idle=1 and any eligible valid is high.
  - Eligible = the locked requester only, if a lock is active; otherwise all requesters.
  - Winner = first valid searching upward from last_grant+1, with modulo NUM_REQ wrap.
  - On the arbitration edge: latch the winner's data and last into o_tx_data, update o_grant_id, set o_busy=1, go to ISSUE.
- ISSUE (exactly 1 cycle):
  - o_tx_valid=1 and o_req_ready[grant]=1.
  - If LOCK_PACKET=1: lock := (last==0).
  - Go to WAIT_BUSY.
  - Grant-to-valid latency: 1 cycle after the ARB edge.
- WAIT_BUSY:
  - When i_tx_idle=0, go to WAIT_DONE.
  - Count cycles; if ACK_TIMEOUT cycles pass with i_tx_idle still 1: pulse o_err_timeout, clear lock, go to ARB.
  - On timeout the byte counts as lost; it was already acked to the requester.
- WAIT_DONE: when i_tx_idle returns to 1, go to GAP if GAP_CYCLES>0, else to ARB with o_busy=0.
- GAP: count GAP_CYCLES cycles, then go to ARB with o_busy=0.
- Lock held and locked requester's valid low: stay in ARB indefinitely; other requesters are not served.
- Simultaneous requests: only round-robin order decides; there is no fixed priority.
- The same requester is never granted twice in a row while another eligible requester is valid, unless the lock is held.
- o_tx_data holds its value until the next grant.
- Back-to-back throughput: at most one byte per frame time plus 3 cycles plus GAP_CYCLES.

Decomposition:
- Shared package uart_pkg: FSM state localparams (ARB/ISSUE/WAIT_BUSY/WAIT_DONE/GAP), default DATA_WIDTH.
- One sub-module: uart_rr_select. Purely combinational round-robin picker with inputs req[NUM_REQ], mask, last_grant and outputs onehot grant, index, any. Unit-testable on its own.
- Top-level uart_tx_arbiter holds the FSM, latches and counters.

Test Plan:
- Single requester: req0 valid, data=0x5A, last=1 -> ready[0] and o_tx_valid pulse 1 cycle after grant; with uart_tx attached at BAUD 9600, line shows start bit, 0x5A LSB first, stop bit; o_busy clears when idle rises.
- Round robin: all 4 valid continuously, last=1 -> grant order 0,1,2,3,0; each gets exactly one ready pulse per 4 frames.
- Packet lock: req1 sends 3 bytes with last=0,0,1 while req2 is valid -> bytes 1,1,1 then 2. With LOCK_PACKET=0 -> 1,2,1,2,1.
- Timeout: i_tx_idle tied high -> o_err_timeout pulses 8 cycles after o_tx_valid, FSM back in ARB, lock cleared, next request re-granted.
- Gap: GAP_CYCLES=5, two queued bytes -> exactly 5 cycles between i_tx_idle rising and next o_tx_valid minus 1 ARB cycle; line stays high throughout.
- Reset mid-frame: assert i_rst_n low during WAIT_DONE -> all outputs 0 immediately; after release, requester 0 has first priority.
